uart_tx_bridge: RTL

//  Real-hardware UART transmit path for the rv32 core's ext_uart_write port. Byte writes are buffered in a

---
 rtl/uart_tx_bridge.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge
//   UART transmit path for the core's byte-write port. Accepted writes are
//   queued in a small circular FIFO and serialised LSB-first onto tx with a
//   start bit, optional parity bit and 1 or 2 stop bits. wr_ready gives real
//   backpressure; writes offered while full are dropped and flagged.
//
// Ports
//   CLK, RST_N   clock (posedge) / asynchronous active-low reset
//   wr_valid     write request, accepted when wr_ready is high
//   wr_data      byte to transmit
//   wr_ready     FIFO not full (registered state only)
//   clr_dropped  clears the dropped flag (a new drop in the same cycle wins)
//   tx           registered serial output, idles high
//   busy         a frame is in flight or bytes are still queued
//   level        FIFO occupancy, 0..FIFO_DEPTH
//   dropped      sticky: a write was offered while the FIFO was full

module uart_tx_bridge #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    input  logic                          clr_dropped,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          dropped
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_LVL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             dropped_q, dropped_d;

    logic             push;
    logic             pop;
    logic             baud_done;
    logic             par_bit;
    logic [2:0]       idx_nx;

    // Ready depends only on the registered level, so a pop while full does
    // not reopen the FIFO until the following cycle.
    assign wr_ready  = (level_q != FULL_LVL);
    assign push      = wr_valid && wr_ready;
    assign baud_done = (baud_q == '0);
    assign par_bit   = (PARITY == 2) ? ~^shreg_q : ^shreg_q;
    assign idx_nx    = idx_q + 3'd1;

    assign tx      = tx_q;
    assign level   = level_q;
    assign dropped = dropped_q;
    assign busy    = (state_q != S_IDLE) || (level_q != '0);

    // FIFO bookkeeping; pointers wrap naturally since depth is a power of 2.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        dropped_d = dropped_q;
        if (wr_valid && !wr_ready) begin
            dropped_d = 1'b1;
        end else if (clr_dropped) begin
            dropped_d = 1'b0;
        end
    end

    // Serialiser. tx_d carries the line value for the state being entered so
    // the registered tx changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = baud_done ? BAUD_LAST : baud_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // Only bytes already queued at cycle start can be popped.
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_LAST;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    if (idx_q == 3'd7) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = S_STOP;
                            idx_d   = '0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_nx;
                        tx_d  = shreg_q[idx_nx];
                    end
                end
            end
            S_PARITY: begin
                if (baud_done) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                // idx counts stop bits here.
                if (baud_done) begin
                    if (idx_q == STOP_LAST) begin
                        if (level_q != '0) begin
                            // Chain straight into the next start bit.
                            pop     = 1'b1;
                            shreg_d = mem_q[rd_ptr_q];
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_nx;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            dropped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            dropped_q <= dropped_d;
        end
    end

endmodule
